// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and write-merge helper for the multi-port register file.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR = 0;
    // Returns {hit, from_port1}; port 1 wins collisions, a locked zero register swallows writes.
    function automatic logic [1:0] wr_merge(input logic we0, input logic we1, input logic hit0,
                                            input logic hit1, input logic zero_lock);
        wr_merge = zero_lock ? 2'b00 : {(we0 && hit0) || (we1 && hit1), we1 && hit1};
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and scoreboard signals of the register file.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0] rd_busy;
    logic we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [2**ADDR_W-1:0] busy_vec;
    modport master (output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr,
                    input rd_data, rd_busy, busy_vec);
    modport slave (input rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr,
                   output rd_data, rd_busy, busy_vec);
endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with write bypass and busy lookup.
module regfile_rdport import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem_i,
    input  logic [2**ADDR_W-1:0] busy_i,
    input  logic we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [DATA_W-1:0] data_o,
    output logic busy_o
);
    logic zero_lock;
    logic [1:0] m;
    always_comb begin
        zero_lock = ZERO_REG != 0 && addr_i == ADDR_W'(ZERO_ADDR);
        m = wr_merge(we0_i, we1_i, waddr0_i == addr_i, waddr1_i == addr_i, zero_lock);
        data_o = zero_lock ? '0 : (BYPASS != 0 && m[1]) ? (m[0] ? wdata1_i : wdata0_i) : mem_i[addr_i];
        busy_o = busy_i[addr_i];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritised writes, bypass and busy scoreboard.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst,
    regfile_mp_if.slave rf_if
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [1:0] m;
    logic zero_lock, we0_v, we1_v;
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be 1..4");
    end
    // Writes held during reset must not leak through the bypass path.
    assign we0_v = rf_if.we0 && !rst;
    assign we1_v = rf_if.we1 && !rst;
    always_comb begin
        mem_d = mem_q;
        busy_d = busy_q;
        m = '0;
        zero_lock = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            zero_lock = ZERO_REG != 0 && r == ZERO_ADDR;
            m = wr_merge(we0_v, we1_v, rf_if.waddr0 == ADDR_W'(r), rf_if.waddr1 == ADDR_W'(r), zero_lock);
            mem_d[r] = m[1] ? (m[0] ? rf_if.wdata1 : rf_if.wdata0) : mem_q[r];
            // A new issue overrides a retiring writeback to the same register.
            busy_d[r] = !zero_lock && ((rf_if.issue_en && rf_if.issue_addr == ADDR_W'(r)) || (busy_q[r] && !m[1]));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            busy_q <= '0;
        end else begin
            mem_q <= mem_d;
            busy_q <= busy_d;
        end
    end
    assign rf_if.busy_vec = busy_q;
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd (
            .addr_i(rf_if.rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_i(mem_q),
            .busy_i(busy_q),
            .we0_i(we0_v),
            .waddr0_i(rf_if.waddr0),
            .wdata0_i(rf_if.wdata0),
            .we1_i(we1_v),
            .waddr1_i(rf_if.waddr1),
            .wdata1_i(rf_if.wdata1),
            .data_o(rf_if.rd_data[i*DATA_W +: DATA_W]),
            .busy_o(rf_if.rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for two regfile_mp configurations sharing one stimulus stream.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic we0, we1, ie;
    logic [4:0] wa0, wa1, ia;
    logic [31:0] wd0, wd1;
    logic [4:0] ra [4];

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) ifa ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    assign ifa.we0 = we0;
    assign ifa.waddr0 = wa0;
    assign ifa.wdata0 = wd0;
    assign ifa.we1 = we1;
    assign ifa.waddr1 = wa1;
    assign ifa.wdata1 = wd1;
    assign ifa.issue_en = ie;
    assign ifa.issue_addr = ia;
    assign ifa.rd_addr = {ra[3], ra[2], ra[1], ra[0]};
    assign ifb.we0 = we0;
    assign ifb.waddr0 = wa0;
    assign ifb.wdata0 = wd0;
    assign ifb.we1 = we1;
    assign ifb.waddr1 = wa1;
    assign ifb.wdata1 = wd1;
    assign ifb.issue_en = ie;
    assign ifb.issue_addr = ia;
    assign ifb.rd_addr = {ra[1], ra[0]};

    // A: zero register + bypass, four read ports. B: plain storage, no bypass, two read ports.
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rf_if(ifa));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rf_if(ifb));

    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [31:0] ba, bb;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        ba = '0;
        bb = '0;
    endtask

    // Writes applied in port order so port 1 overwrites; busy clears first then issue sets.
    always @(posedge clk) begin
        if (!rst) begin
            if (we0 && wa0 != 0) ma[wa0] = wd0;
            if (we1 && wa1 != 0) ma[wa1] = wd1;
            if (we0) mb[wa0] = wd0;
            if (we1) mb[wa1] = wd1;
            if (we0) begin ba[wa0] = 1'b0; bb[wa0] = 1'b0; end
            if (we1) begin ba[wa1] = 1'b0; bb[wa1] = 1'b0; end
            if (ie) begin ba[ia] = 1'b1; bb[ia] = 1'b1; end
            ba[0] = 1'b0;
        end
    end

    function automatic logic [31:0] rd_a(logic [4:0] a);
        if (rst || a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return ma[a];
    endfunction

    function automatic logic [31:0] rd_b(logic [4:0] a);
        return rst ? '0 : mb[a];
    endfunction

    typedef struct {
        string tag;
        logic [127:0] rda;
        logic [3:0] rba;
        logic [31:0] bva;
        logic [63:0] rdb;
        logic [1:0] rbb;
        logic [31:0] bvb;
    } exp_t;
    exp_t q [$];

    task automatic push(string tag);
        exp_t e;
        e.tag = tag;
        for (int i = 0; i < 4; i++) begin
            e.rda[i*32 +: 32] = rd_a(ra[i]);
            e.rba[i] = ba[ra[i]];
        end
        for (int i = 0; i < 2; i++) begin
            e.rdb[i*32 +: 32] = rd_b(ra[i]);
            e.rbb[i] = bb[ra[i]];
        end
        e.bva = ba;
        e.bvb = bb;
        q.push_back(e);
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, string field, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got %h exp %h", tag, field, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "rd_data_a", 128'(ifa.rd_data), e.rda);
                chk(e.tag, "rd_busy_a", 128'(ifa.rd_busy), 128'(e.rba));
                chk(e.tag, "busy_vec_a", 128'(ifa.busy_vec), 128'(e.bva));
                chk(e.tag, "rd_data_b", 128'(ifb.rd_data), 128'(e.rdb));
                chk(e.tag, "rd_busy_b", 128'(ifb.rd_busy), 128'(e.rbb));
                chk(e.tag, "busy_vec_b", 128'(ifb.busy_vec), 128'(e.bvb));
            end
        end
    end

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; ie = 1'b0;
        wa0 = '0; wa1 = '0; ia = '0;
        wd0 = '0; wd1 = '0;
        for (int i = 0; i < 4; i++) ra[i] = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Asserts reset mid-cycle with the current inputs still driven; checked before any clk edge.
    task automatic pulse_rst(string tag);
        #1;
        rst = 1'b1;
        model_reset();
        push(tag);
        @(negedge clk);
        #1;
        we0 = 1'b0; we1 = 1'b0; ie = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        @(posedge clk);
        #1;
        push("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        next(); we0 = 1; wa0 = 3; wd0 = 32'h12345678; ra[0] = 3; push("wr_same_cycle");
        next(); ra[0] = 3; push("wr_next_cycle");
        next(); we0 = 1; wa0 = 9; wd0 = 32'h1111; we1 = 1; wa1 = 9; wd1 = 32'h2222; ra[0] = 9; push("collide_same");
        next(); ra[0] = 9; ra[1] = 9; push("collide_after");
        next(); we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; ie = 1; ia = 0; push("zero_during");
        next(); ra[1] = 0; push("zero_after");
        next(); ie = 1; ia = 4; ra[0] = 4; push("sb_issue");
        next(); we0 = 1; wa0 = 4; wd0 = 32'h44; ra[0] = 4; push("sb_wb_cycle");
        next(); ra[0] = 4; push("sb_cleared");
        next(); ie = 1; ia = 4; we1 = 1; wa1 = 4; wd1 = 32'h55; ra[0] = 4; push("sb_set_and_clear");
        next(); ra[0] = 4; push("sb_set_wins");
        next(); we0 = 1; wa0 = 1; wd0 = 1; we1 = 1; wa1 = 2; wd1 = 2; push("mp_fill0");
        next(); we0 = 1; wa0 = 3; wd0 = 3; we1 = 1; wa1 = 4; wd1 = 4; push("mp_fill1");
        next(); ra[0] = 4; ra[1] = 3; ra[2] = 2; ra[3] = 1; push("mp_read");
        next(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; push("pre_rst_wr");
        next(); ie = 1; ia = 7; ra[0] = 5; ra[1] = 7; push("pre_rst_issue");
        next(); ra[0] = 5; ra[1] = 7; push("pre_rst_state");
        next(); ra[0] = 5; ra[1] = 7; we0 = 1; wa0 = 5; wd0 = 32'hCAFE; ie = 1; ia = 6; pulse_rst("async_rst");
        next(); ra[0] = 5; ra[1] = 7; push("post_rst");
        for (int n = 0; n < 400; n++) begin
            next();
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wa0 = 5'($urandom_range(0, 7));
            wa1 = 5'($urandom_range(0, 7));
            ia = 5'($urandom_range(0, 7));
            wd0 = $urandom;
            wd1 = $urandom;
            for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) pulse_rst("rand_rst");
            else push("rand");
        end
        next();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
